// File: rtl/xava_result_queue.sv
// xava_result_queue: in-order pairing of issued writeback tags with accelerator results onto the X-IF result handshake.
// Define XAVA_RESULT_BYPASS_EN to present a result in its arrival cycle when the data FIFO is empty.
module xava_result_queue #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_fire_i,
    input  logic [ID_W-1:0]   issue_id_i,
    input  logic [4:0]        issue_rd_i,
    output logic              tag_full_o,
    input  logic              apu_rvalid_i,
    input  logic [DATA_W-1:0] apu_result_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [ID_W-1:0]   result_id_o,
    output logic [4:0]        result_rd_o,
    output logic [DATA_W-1:0] result_data_o,
    output logic              result_we_o,
    output logic              err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = ID_W + 5;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [TW-1:0]     tag_mem_q [DEPTH];
    logic [TW-1:0]     tag_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]     tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [PW-1:0]     data_wp_q, data_wp_d, data_rp_q, data_rp_d;
    logic [CW-1:0]     tag_cnt_q, tag_cnt_d, data_cnt_q, data_cnt_d;
    logic              err_q, err_d;
    logic              has_tag, byp, valid, tag_push, tag_pop, data_push, data_pop;

    always_comb begin
        has_tag   = tag_cnt_q > data_cnt_q;
`ifdef XAVA_RESULT_BYPASS_EN
        byp       = apu_rvalid_i && data_cnt_q == '0 && tag_cnt_q != '0;
`else
        byp       = 1'b0;
`endif
        valid     = data_cnt_q != '0 || byp;
        tag_pop   = valid && result_ready_i;
        data_pop  = tag_pop && !byp;
        tag_push  = issue_fire_i && tag_cnt_q != FULL;
        // a bypassed result that retires immediately never occupies a slot
        data_push = apu_rvalid_i && has_tag && !(byp && result_ready_i);
        err_d      = err_q || (issue_fire_i && !tag_push) || (apu_rvalid_i && !has_tag);
        tag_cnt_d  = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        data_cnt_d = data_cnt_q + CW'(data_push) - CW'(data_pop);
        tag_wp_d   = tag_push ? tag_wp_q + 1'b1 : tag_wp_q;
        tag_rp_d   = tag_pop ? tag_rp_q + 1'b1 : tag_rp_q;
        data_wp_d  = data_push ? data_wp_q + 1'b1 : data_wp_q;
        data_rp_d  = data_pop ? data_rp_q + 1'b1 : data_rp_q;
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        if (tag_push) tag_mem_d[tag_wp_q] = {issue_id_i, issue_rd_i};
        if (data_push) data_mem_d[data_wp_q] = apu_result_i;
    end

    always_comb begin
        tag_full_o                 = tag_cnt_q == FULL;
        result_valid_o             = valid;
        result_we_o                = valid;
        err_o                      = err_q;
        {result_id_o, result_rd_o} = valid ? tag_mem_q[tag_rp_q] : '0;
        result_data_o              = !valid ? '0 : byp ? apu_result_i : data_mem_q[data_rp_q];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
            data_wp_q  <= '0;
            data_rp_q  <= '0;
            tag_cnt_q  <= '0;
            data_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            tag_wp_q   <= tag_wp_d;
            tag_rp_q   <= tag_rp_d;
            data_wp_q  <= data_wp_d;
            data_rp_q  <= data_rp_d;
            tag_cnt_q  <= tag_cnt_d;
            data_cnt_q <= data_cnt_d;
            err_q      <= err_d;
        end
    end

    // storage needs no reset: counts gate every read
    always_ff @(posedge clk_i) begin
        tag_mem_q  <= tag_mem_d;
        data_mem_q <= data_mem_d;
    end
endmodule

// File: tb/tb_xava_result_queue.sv
// tb_xava_result_queue: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_xava_result_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_fire = 1'b0;
    logic [3:0]  issue_id = '0;
    logic [4:0]  issue_rd = '0;
    logic        tag_full;
    logic        apu_rvalid = 1'b0;
    logic [31:0] apu_result = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  result_id;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic        result_we;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    xava_result_queue dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_fire_i(issue_fire), .issue_id_i(issue_id), .issue_rd_i(issue_rd),
        .tag_full_o(tag_full),
        .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_id_o(result_id), .result_rd_o(result_rd), .result_data_o(result_data),
        .result_we_o(result_we), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [3:0] id;
        logic [4:0] rd;
    } tag_t;
    tag_t        tq[$];
    logic [31:0] dq[$];
    logic        m_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // outstanding tags and results as plain queues; one result retires per accepted handshake
    task automatic model_update();
        bit pop, tpush, dpush;
        if (!rst_n) begin
            tq.delete();
            dq.delete();
            m_err = 1'b0;
        end else begin
            pop   = dq.size() != 0 && result_ready;
            tpush = issue_fire && tq.size() < 4;
            dpush = apu_rvalid && tq.size() > dq.size();
            if ((issue_fire && !tpush) || (apu_rvalid && !dpush)) m_err = 1'b1;
            if (pop) begin
                void'(tq.pop_front());
                void'(dq.pop_front());
            end
            if (tpush) tq.push_back('{issue_id, issue_rd});
            if (dpush) dq.push_back(apu_result);
        end
    endtask

    task automatic model_check();
        bit v;
        v = dq.size() != 0;
        chk("model.valid", result_valid, v);
        chk("model.we", result_we, v);
        chk("model.id", result_id, v ? tq[0].id : 4'd0);
        chk("model.rd", result_rd, v ? tq[0].rd : 5'd0);
        chk("model.data", result_data, v ? dq[0] : 32'd0);
        chk("model.full", tag_full, tq.size() == 4);
        chk("model.err", err, m_err);
    endtask

    task automatic cyc(input logic r, input logic f, input logic [3:0] id, input logic [4:0] rd,
                       input logic rv, input logic [31:0] d, input logic rdy);
        @(posedge clk);
        model_update();
        #1;
        rst_n = r; issue_fire = f; issue_id = id; issue_rd = rd;
        apu_rvalid = rv; apu_result = d; result_ready = rdy;
        @(negedge clk);
        model_check();
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [3:0] id, input logic [4:0] rd,
                              input logic [31:0] d, input logic full, input logic e);
        chk({nm, ".valid"}, result_valid, v);
        chk({nm, ".we"}, result_we, v);
        chk({nm, ".id"}, result_id, id);
        chk({nm, ".rd"}, result_rd, rd);
        chk({nm, ".data"}, result_data, d);
        chk({nm, ".full"}, tag_full, full);
        chk({nm, ".err"}, err, e);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic f; logic [3:0] id; logic [4:0] rd; logic rv; logic [31:0] d; logic rdy;
        logic ev; logic [3:0] eid; logic [4:0] erd; logic [31:0] ed; logic efull; logic eerr;
    } vec_t;
    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 3, 5, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1,            1, 3, 5, 32'hDEADBEEF, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 2, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 2, 3, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 3, 4, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 5, 6, 0, 0, 0,            0, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 32'h100, 1,      0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 1, 32'h101, 1,      1, 0, 1, 32'h100, 1, 1};
        tbl[12] = '{0, 0, 0, 1, 32'h102, 1,      1, 1, 2, 32'h101, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 32'h103, 1,      1, 2, 3, 32'h102, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 1,            1, 3, 4, 32'h103, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 1};

        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, tbl[i].f, tbl[i].id, tbl[i].rd, tbl[i].rv, tbl[i].d, tbl[i].rdy);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].erd, tbl[i].ed, tbl[i].efull, tbl[i].eerr);
        end

        // backpressure: outputs hold for six stalled cycles, then exactly one retirement
        do_reset();
        cyc(1, 1, 6, 12, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hCAFE0001, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            expect_out("bp_hold", 1, 6, 12, 32'hCAFE0001, 0, 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("bp_retire", 1, 6, 12, 32'hCAFE0001, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("bp_nodup", 0, 0, 0, 0, 0, 0);

        // issue at full coincident with a pop is still rejected
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 1, 4'(k), 5'(k + 16), 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hA0, 0);
        cyc(1, 1, 7, 7, 0, 0, 1);
        expect_out("full_pop", 1, 0, 16, 32'hA0, 1, 0);
        cyc(1, 0, 0, 0, 1, 32'hA1, 1);
        expect_out("full_rej", 0, 0, 0, 0, 0, 1);
        for (int k = 2; k < 4; k++) begin
            cyc(1, 0, 0, 0, 1, 32'hA0 + 32'(k), 1);
            expect_out("full_order", 1, 4'(k - 1), 5'(k + 15), 32'hA0 + 32'(k - 1), 0, 1);
        end
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("full_last", 1, 3, 19, 32'hA3, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("full_drain", 0, 0, 0, 0, 0, 1);

        // push and pop together at count 2
        do_reset();
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(1, 1, 2, 2, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hB1, 0);
        cyc(1, 1, 3, 3, 0, 0, 1);
        expect_out("pp_a", 1, 1, 1, 32'hB1, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hB2, 1);
        expect_out("pp_gap", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'hB3, 1);
        expect_out("pp_b", 1, 2, 2, 32'hB2, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("pp_c", 1, 3, 3, 32'hB3, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("pp_empty", 0, 0, 0, 0, 0, 0);

        // orphan result
        do_reset();
        cyc(1, 0, 0, 0, 1, 32'h77, 1);
        expect_out("orphan_pre", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("orphan", 0, 0, 0, 0, 0, 1);

        // reset with work in flight, then a fresh transaction
        for (int k = 1; k < 4; k++) cyc(1, 1, 4'(k), 5'(k + 6), 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h11, 0);
        cyc(1, 0, 0, 0, 1, 32'h22, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        expect_out("rst_pending", 1, 1, 7, 32'h11, 0, 1);
        cyc(1, 1, 9, 10, 0, 0, 0);
        expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h55, 1);
        expect_out("rst_fresh_wait", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("rst_fresh", 1, 9, 10, 32'h55, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        expect_out("rst_fresh_done", 0, 0, 0, 0, 0, 0);

        // random traffic, including issues at full, orphans and occasional resets
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 4, 4'($urandom), 5'($urandom),
                $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 6);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
